// File: rtl/uart_packetizer.sv
// Frames a payload byte stream as header, length, payload, XOR checksum and
// buffers the framed bytes in a first-word-fall-through FIFO for uart_tx.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for i_pkt_start; zero length flags o_len_error
// S_HEADER  | pushing HEADER_BYTE once the FIFO has room
// S_LENGTH  | pushing the latched length byte; checksum seeded with it
// S_PAYLOAD | accepting payload bytes until the remaining count runs out
// S_CHECKSUM| pushing the accumulated checksum, then back to idle
module uart_packetizer #(
  parameter int         FIFO_DEPTH  = 16,
  parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_pkt_start,
  input  logic [7:0] i_pkt_len,
  input  logic [7:0] i_data_in,
  input  logic       i_data_valid,
  output logic       o_data_ready,
  output logic       o_pkt_busy,
  output logic       o_pkt_done,
  output logic       o_len_error,
  input  logic       i_fifo_read,
  output logic       o_fifo_empty,
  output logic       o_fifo_full,
  output logic [7:0] o_fifo_data_out
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_LENGTH,
    S_PAYLOAD,
    S_CHECKSUM
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_len;
  logic [7:0]      r_remaining;
  logic [7:0]      r_csum;
  logic            r_pkt_done;
  logic            r_len_error;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [7:0]      w_push_data;
  logic            w_data_ready;
  logic            w_accept;
  logic            w_len_err;
  logic            w_done;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_pop   = i_fifo_read && !w_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_push       = 1'b0;
    w_push_data  = 8'h00;
    w_data_ready = 1'b0;
    w_accept     = 1'b0;
    w_len_err    = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_pkt_start) begin
          if (i_pkt_len != 8'd0) begin
            w_accept    = 1'b1;
            w_state_nxt = S_HEADER;
          end else begin
            w_len_err = 1'b1;
          end
        end
      end
      S_HEADER: begin
        if (!w_full) begin
          w_push      = 1'b1;
          w_push_data = HEADER_BYTE;
          w_state_nxt = S_LENGTH;
        end
      end
      S_LENGTH: begin
        if (!w_full) begin
          w_push      = 1'b1;
          w_push_data = r_len;
          w_state_nxt = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        w_data_ready = !w_full;
        if (i_data_valid && !w_full) begin
          w_push      = 1'b1;
          w_push_data = i_data_in;
          if (r_remaining == 8'd1) w_state_nxt = S_CHECKSUM;
        end
      end
      S_CHECKSUM: begin
        if (!w_full) begin
          w_push      = 1'b1;
          w_push_data = r_csum;
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len       <= 8'd0;
      r_remaining <= 8'd0;
      r_csum      <= 8'd0;
      r_pkt_done  <= 1'b0;
      r_len_error <= 1'b0;
    end else begin
      r_pkt_done  <= w_done;
      r_len_error <= w_len_err;
      if (w_accept) begin
        r_len       <= i_pkt_len;
        r_remaining <= i_pkt_len;
      end
      if (w_push && r_state == S_LENGTH) r_csum <= r_len;
      if (w_push && r_state == S_PAYLOAD) begin
        r_csum      <= r_csum ^ i_data_in;
        r_remaining <= r_remaining - 8'd1;
      end
    end
  end

  // Storage is deliberately not reset; the pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data_ready    = w_data_ready;
  assign o_pkt_busy      = (r_state != S_IDLE);
  assign o_pkt_done      = r_pkt_done;
  assign o_len_error     = r_len_error;
  assign o_fifo_empty    = w_empty;
  assign o_fifo_full     = w_full;
  assign o_fifo_data_out = r_mem[r_rd_ptr];

endmodule
